// File: rtl/cic_comb_upsample.sv
// Purpose: CIC interpolator front end; N comb stages (delay M) at the input rate, then zero-stuff by R.
// Latency: ena/out are registered one clk after each strobe slot; a held sample leaves on the next phase-0 slot.
// Backpressure: one-entry holding register; in_ready = register empty. An empty phase-0 slot emits 0 and sets sticky underrun.
module cic_comb_upsample #(
    parameter int BITWIDTH = 32,
    parameter int IN_W     = 16,
    parameter int N        = 3,
    parameter int M        = 1,
    parameter int R        = 8,
    parameter int CLK_DIV  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_W-1:0]     in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                ena,
    output logic [BITWIDTH-1:0] out,
    output logic                underrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PH_W  = $clog2(R);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic [PH_W-1:0]     r_phase;
    logic [BITWIDTH-1:0] r_hold;
    logic                r_hold_full;
    // r_z[k][j]: stage k input delayed by j+1 low-rate samples
    logic [BITWIDTH-1:0] r_z [N][M];

    logic [BITWIDTH-1:0] w_xin [N];
    logic [BITWIDTH-1:0] w_xout [N];
    logic                w_push;
    logic                w_slot;

    // The holding register is the only thing gating acceptance; nothing is accepted while reset is held.
    assign in_ready = !rst && !r_hold_full;
    assign w_push   = in_valid && in_ready;
    assign w_slot   = (r_state == S_RUN) && (r_div == DIV_W'(CLK_DIV - 1));

    // Comb cascade on the held sample: each stage subtracts its input from M samples ago.
    always_comb begin
        logic [BITWIDTH-1:0] v_x;
        v_x = r_hold;
        for (int k = 0; k < N; k++) begin
            w_xin[k]  = v_x;
            w_xout[k] = v_x - r_z[k][M-1];
            v_x       = w_xout[k];
        end
    end

    // Control FSM, rate divider, phase counter, holding register, comb delay lines and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_phase     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            ena         <= 1'b0;
            out         <= '0;
            underrun    <= 1'b0;
            for (int k = 0; k < N; k++) begin
                for (int j = 0; j < M; j++) begin
                    r_z[k][j] <= '0;
                end
            end
        end else begin
            ena <= 1'b0;

            // Push and pop are mutually exclusive: push needs an empty register, pop a full one.
            if (w_push) begin
                r_hold      <= BITWIDTH'(signed'(in_data));
                r_hold_full <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_div <= '0;
                    if (r_hold_full) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_slot) begin
                        r_div <= '0;
                        ena   <= 1'b1;
                        if (r_phase == PH_W'(R - 1)) begin
                            r_phase <= '0;
                        end else begin
                            r_phase <= r_phase + PH_W'(1);
                        end

                        if (r_phase == '0) begin
                            if (r_hold_full) begin
                                r_hold_full <= 1'b0;
                                out         <= w_xout[N-1];
                                for (int k = 0; k < N; k++) begin
                                    r_z[k][0] <= w_xin[k];
                                    for (int j = 1; j < M; j++) begin
                                        r_z[k][j] <= r_z[k][j-1];
                                    end
                                end
                            end else begin
                                // Keep the output rate: emit a zero and leave the comb state untouched.
                                out      <= '0;
                                underrun <= 1'b1;
                            end
                        end else begin
                            out <= '0;
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cic_comb_upsample.sv
// Purpose: scoreboard bench for cic_comb_upsample (N=2, M=2, R=4, CLK_DIV=3).
// Latency: expected frames are queued at push time and consumed on every ena pulse.
// Backpressure: driver waits on in_ready (bounded) and deliberately withholds one sample to force underrun.
module tb_cic_comb_upsample;

    localparam int BW      = 32;
    localparam int IW      = 16;
    localparam int N       = 2;
    localparam int M       = 2;
    localparam int R       = 4;
    localparam int CLK_DIV = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          ena;
    logic [BW-1:0] out;
    logic          underrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [BW-1:0] sb [$];
    logic [BW-1:0] mz [N][M];

    always #5 clk = ~clk;

    cic_comb_upsample #(
        .BITWIDTH (BW),
        .IN_W     (IW),
        .N        (N),
        .M        (M),
        .R        (R),
        .CLK_DIV  (CLK_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ena      (ena),
        .out      (out),
        .underrun (underrun)
    );

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < M; j++) begin
                mz[k][j] = '0;
            end
        end
    endtask

    // Reference comb: y_k = x_k - x_k[n-M], then the frame is the result followed by R-1 zeros.
    task automatic model_frame(input logic [IW-1:0] v);
        logic [BW-1:0] x;
        logic [BW-1:0] y;
        x = BW'(signed'(v));
        for (int k = 0; k < N; k++) begin
            y = x - mz[k][M-1];
            for (int j = M - 1; j > 0; j--) begin
                mz[k][j] = mz[k][j-1];
            end
            mz[k][0] = x;
            x = y;
        end
        sb.push_back(x);
        for (int i = 1; i < R; i++) begin
            sb.push_back('0);
        end
    endtask

    // Called at a negedge with the holding register expected empty.
    task automatic push(input logic [IW-1:0] v);
        check("rdy_hi", {31'b0, in_ready}, 1);
        in_valid = 1'b1;
        in_data  = v;
        model_frame(v);
        @(negedge clk);
        in_valid = 1'b0;
        check("rdy_fall", {31'b0, in_ready}, 0);
    endtask

    // in_ready must come back together with the phase-0 ena that popped the sample.
    task automatic wait_pop();
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("pop_timeout", {31'b0, in_ready}, 1);
        end else begin
            check("ena_at_rdy", {31'b0, ena}, 1);
        end
    endtask

    // Monitor: every ena pulse pops one expected value; pulses must be CLK_DIV clocks apart.
    initial begin
        int  gap;
        bit  seen;
        gap  = 0;
        seen = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                gap  = 0;
                seen = 0;
            end else begin
                gap++;
                if (ena) begin
                    if (seen) check("ena_gap", gap, CLK_DIV);
                    seen = 1;
                    gap  = 0;
                    if (sb.size() == 0) begin
                        check("sb_depth", sb.size(), 1);
                    end else begin
                        check("out", out, sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int t;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_ena", {31'b0, ena}, 0);
        check("rst_out", out, 0);
        check("rst_underrun", {31'b0, underrun}, 0);
        check("rst_rdy", {31'b0, in_ready}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ena", {31'b0, ena}, 0);

        // Sign extension first, then an impulse and assorted values.
        push(16'h8000); wait_pop();
        push(16'h0001); wait_pop();
        push(16'h0000); wait_pop();
        push(16'h0000); wait_pop();
        push(16'h7fff); wait_pop();
        check("no_underrun", {31'b0, underrun}, 0);
        push(16'hfffb); wait_pop();

        // Withhold a sample past the next phase-0 slot: one zero frame, comb state preserved.
        for (int i = 0; i < R; i++) sb.push_back('0);
        repeat (15) @(negedge clk);
        check("underrun_set", {31'b0, underrun}, 1);
        push(16'd100); wait_pop();
        push(16'd3);   wait_pop();
        check("underrun_sticky", {31'b0, underrun}, 1);

        // One-cycle reset mid-stream.
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ena", {31'b0, ena}, 0);
        check("mid_rst_rdy", {31'b0, in_ready}, 0);
        check("mid_rst_underrun", {31'b0, underrun}, 0);
        rst = 1'b0;
        sb.delete();
        model_clear();
        repeat (6) begin
            @(negedge clk);
            check("post_rst_idle", {31'b0, ena}, 0);
        end
        push(16'd7);    wait_pop();
        push(16'hffff); wait_pop();
        push(16'd9);    wait_pop();

        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain", sb.size(), 0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
